prince_sbox_layer_sched: RTL and testbench
==========================================

# prince_sbox_layer_sched

Scheduler for the masked (CMS, three-share) PRINCE S-box layer. Applies one pipelined shared S-box core to all nibbles of the shared 64-bit state, one nibble per cycle. The block owns nibble sequencing, fresh-randomness handshaking, pipeline-valid tracking and write-back addressing. It sits between the round controller and the S-box core / state share registers; it computes no share data itself.

## Interface
Parameters:
- NIBBLES, default 16: nibbles per layer; must be ≥ 2.
- LAT, default 2: register stages in the S-box core, from issue to result; must be ≥ 1.
- IW, default 4: index width; must satisfy 2^IW ≥ NIBBLES.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request one layer pass; sampled only in IDLE.
- rnd_valid, input, 1: the fresh-mask source presents valid randomness this cycle.
- rnd_ack, output, 1: randomness consumed this cycle; identical to issue.
- issue, output, 1: core input mux loads nibble sel_idx this cycle.
- sel_idx, output, IW: nibble index routed to the core input.
- wr_en, output, 1: core output is valid; write it to state nibble wr_idx.
- wr_idx, output, IW: write-back nibble index.
- busy, output, 1: a pass is in progress.
- done, output, 1: one-cycle pulse when a pass completes.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if start=1, go to ISSUE and clear iss_cnt. start is ignored in every other state.
- ISSUE: issue = rnd_valid. On each issue, iss_cnt increments.
  - When the issue with iss_cnt = NIBBLES-1 occurs, go to DRAIN.
  - With rnd_valid=0, nothing is issued and a bubble enters the pipeline.
- DRAIN: no issues. When the last valid token leaves the pipeline (wr_en with wr_idx = NIBBLES-1), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Pipeline tracking: a LAT-deep shift register of {valid, idx}.
  - Each stage advances every cycle while not in IDLE. The core is never frozen, so the shares in each stage always see fresh masks at a consistent cadence.
  - Stage 0 is loaded with {issue, sel_idx}.
  - wr_en and wr_idx come from the last stage.
- sel_idx = iss_cnt; it is 0 outside ISSUE.
- rnd_ack = issue. Randomness is consumed only on an actual issue, never on a bubble.
- Indices are issued in strictly ascending order 0..NIBBLES-1 and retired in the same order. Bubbles preserve order.
- busy = 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
- Reset, including mid-pass: state becomes IDLE; counters and the valid pipeline are cleared; all outputs go to 0. No partial write-back occurs after reset is released.

## Timing
- Reset values: rnd_ack, issue, sel_idx, wr_en, wr_idx, busy and done are all 0.
- Outputs are combinational from registered state only. rnd_ack and issue also depend combinationally on rnd_valid.
- Cycle numbering: start is sampled high at edge 0; cycle 1 is the first ISSUE cycle.
- Issue latency: a nibble issued in cycle c is written back (wr_en=1) in cycle c+LAT.
- No stalls, LAT=2, NIBBLES=16:
  - issues occur in cycles 1..16;
  - writes occur in cycles 3..18;
  - DRAIN covers cycles 17..18;
  - done is high in cycle 19;
  - busy is high in cycles 1..18.
- Each rnd_valid=0 cycle in ISSUE delays every later issue, write and done by one cycle.
- rnd_valid stuck at 0: the block stays in ISSUE indefinitely with no timeout. Writes already in flight still drain.
- start held high continuously: a new pass begins in the cycle after DONE, so passes are separated by one IDLE cycle.

## Test plan
- Nominal pass (LAT=2, NIBBLES=16, rnd_valid=1): start at edge 0 gives issue with sel_idx=0..15 in cycles 1..16, wr_en with wr_idx=0..15 in cycles 3..18, done=1 only in cycle 19, and busy low again from cycle 19.
- Randomness stalls: rnd_valid=0 in cycles 3 and 10 gives no rnd_ack in those cycles, a bubble in wr_en in cycles 5 and 12, the last write in cycle 20, done in cycle 21, and exactly 16 rnd_ack pulses.
- start while busy: pulse start in cycle 8 → no effect; exactly one done, in cycle 19.
- Reset mid-pass: assert rst_n=0 in cycle 10 → all outputs 0 asynchronously. After release: no wr_en, and the block stays in IDLE until the next start. A following start runs a clean 16-nibble pass.
- Back-to-back passes (start held high): second pass issues nibble 0 in cycle 21 (cycle 20 IDLE); second done in cycle 39.
- LAT=1 variant: no stalls gives writes in cycles 2..17 and done in cycle 18.

Source files
------------

// File: rtl/prince_sbox_layer_sched.sv
// Nibble scheduler for a shared (three-share CMS) PRINCE S-box layer: sequences one
// pipelined core over every nibble, paces issue on fresh randomness and tracks write-back.
`timescale 1ns/1ps

module prince_sbox_layer_sched #(
    parameter int NIBBLES = 16,
    parameter int LAT     = 2,
    parameter int IW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rnd_valid,
    output logic          rnd_ack,
    output logic          issue,
    output logic [IW-1:0] sel_idx,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   iss_cnt_q, iss_cnt_d;
    logic [LAT-1:0]  vld_q;
    logic [IW-1:0]   idx_q [LAT];

    always_comb begin
        issue   = (state_q == ISSUE) && rnd_valid;
        rnd_ack = issue;
        sel_idx = (state_q == ISSUE) ? iss_cnt_q : '0;
        wr_en   = vld_q[LAT-1];
        wr_idx  = idx_q[LAT-1];
        busy    = (state_q == ISSUE) || (state_q == DRAIN);
        done    = (state_q == DONE);
    end

    // The pass ends on the retirement of the highest index, not on a cycle count,
    // so bubbles in the pipeline stretch DRAIN naturally.
    always_comb begin
        state_d   = state_q;
        iss_cnt_d = iss_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    iss_cnt_d = '0;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (iss_cnt_q == LAST_IDX) begin
                        state_d   = DRAIN;
                        iss_cnt_d = '0;
                    end else begin
                        iss_cnt_d = iss_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (wr_en && (wr_idx == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                iss_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
        end
    end

    // Token pipeline mirrors the core stages; it never freezes outside IDLE so
    // every stage keeps a steady mask-refresh cadence even across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else if (state_q != IDLE) begin
            vld_q[0] <= issue;
            idx_q[0] <= issue ? sel_idx : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_prince_sbox_layer_sched.sv
// Scoreboard bench: two schedulers (LAT=2 and LAT=1) share stimulus; an event-level
// model predicts issue/busy/done per cycle and queues expected write-backs.
`timescale 1ns/1ps

module tb_prince_sbox_layer_sched;

    localparam int N  = 16;
    localparam int IW = 4;

    typedef struct {
        int cyc;
        int idx;
    } wrExp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic rnd_valid = 1'b0;

    logic [1:0]    issueV, ackV, wrEnV, busyV, doneV;
    logic [IW-1:0] selV   [2];
    logic [IW-1:0] wrIdxV [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per DUT: pass active, nibbles issued, cycle of expected done.
    bit mActive   [2];
    int mIssued   [2];
    int mDoneCyc  [2];
    int lat       [2];
    wrExp_t q0[$];
    wrExp_t q1[$];

    prince_sbox_layer_sched #(.NIBBLES(N), .LAT(2), .IW(IW)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_valid(rnd_valid),
        .rnd_ack(ackV[0]), .issue(issueV[0]), .sel_idx(selV[0]),
        .wr_en(wrEnV[0]), .wr_idx(wrIdxV[0]), .busy(busyV[0]), .done(doneV[0])
    );

    prince_sbox_layer_sched #(.NIBBLES(N), .LAT(1), .IW(IW)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_valid(rnd_valid),
        .rnd_ack(ackV[1]), .issue(issueV[1]), .sel_idx(selV[1]),
        .wr_en(wrEnV[1]), .wr_idx(wrIdxV[1]), .busy(busyV[1]), .done(doneV[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mActive[d]  = 1'b0;
            mIssued[d]  = 0;
            mDoneCyc[d] = -1;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic modelCycle(input int d, input bit st, input bit rv);
        bit     running;
        bit     expIssue;
        int     expSel;
        wrExp_t e;
        string  p;
        p        = (d == 0) ? "lat2_" : "lat1_";
        running  = mActive[d];
        expIssue = running && (mIssued[d] < N) && rv;
        expSel   = (running && (mIssued[d] < N)) ? mIssued[d] : 0;
        checkOutput({p, "issue"}, issueV[d], expIssue);
        checkOutput({p, "rnd_ack"}, ackV[d], expIssue);
        checkOutput({p, "sel_idx"}, selV[d], expSel);
        checkOutput({p, "busy"}, busyV[d], running);
        checkOutput({p, "done"}, doneV[d], cyc == mDoneCyc[d]);
        if (expIssue) begin
            e.cyc = cyc + lat[d];
            e.idx = mIssued[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            mIssued[d]++;
            if (mIssued[d] == N) mDoneCyc[d] = cyc + lat[d] + 1;
        end
        if (running && (mIssued[d] == N) && (cyc == mDoneCyc[d] - 1)) begin
            mActive[d] = 1'b0;
        end else if (!running && (cyc != mDoneCyc[d]) && st) begin
            mActive[d] = 1'b1;
            mIssued[d] = 0;
        end
    endtask

    task automatic applyStimulus(input bit st, input bit rv);
        @(posedge clk);
        #1;
        start     = st;
        rnd_valid = rv;
        @(negedge clk);
        modelCycle(0, st, rv);
        modelCycle(1, st, rv);
    endtask

    task automatic checkAllZero(input string name);
        for (int d = 0; d < 2; d++) begin
            checkOutput({name, "_issue"}, issueV[d], 0);
            checkOutput({name, "_rnd_ack"}, ackV[d], 0);
            checkOutput({name, "_sel_idx"}, selV[d], 0);
            checkOutput({name, "_wr_en"}, wrEnV[d], 0);
            checkOutput({name, "_wr_idx"}, wrIdxV[d], 0);
            checkOutput({name, "_busy"}, busyV[d], 0);
            checkOutput({name, "_done"}, doneV[d], 0);
        end
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        start     = 1'b0;
        rnd_valid = 1'b1;
        #1;
        checkAllZero("reset");
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Write-back monitor: each wr_en pops the oldest expected write and checks
    // its index and cycle; expected writes whose cycle passed are flagged missing.
    always @(negedge clk) begin
        wrExp_t e;
        if (rst_n) begin
            while (q0.size() > 0 && q0[0].cyc < cyc) begin
                e = q0.pop_front();
                checkOutput("lat2_write_missing_idx", -1, e.idx);
            end
            if (wrEnV[0]) begin
                if (q0.size() == 0) begin
                    checkOutput("lat2_unexpected_write", 1, 0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("lat2_wr_idx", wrIdxV[0], e.idx);
                    checkOutput("lat2_wr_cycle", cyc, e.cyc);
                end
            end
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                e = q1.pop_front();
                checkOutput("lat1_write_missing_idx", -1, e.idx);
            end
            if (wrEnV[1]) begin
                if (q1.size() == 0) begin
                    checkOutput("lat1_unexpected_write", 1, 0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("lat1_wr_idx", wrIdxV[1], e.idx);
                    checkOutput("lat1_wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        modelReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] nominal pass");
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 24; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomness stalls");
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 26; i++) applyStimulus(1'b0, !(i == 3 || i == 10));

        $display("[TB] start while busy");
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 24; i++) applyStimulus(i == 8, 1'b1);

        $display("[TB] reset mid-pass");
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b1);
        resetPulse();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 24; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] back-to-back passes");
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomness stuck low");
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);

        checkOutput("lat2_pending_writes", q0.size(), 0);
        checkOutput("lat1_pending_writes", q1.size(), 0);
        checkOutput("lat2_idle_at_end", mActive[0], 0);
        checkOutput("lat1_idle_at_end", mActive[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
